// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage load/store requests into single data-memory
// accesses, aligning store lanes and extracting load lanes, with an ack timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic        w_req_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Illegal funct3 for the direction, or a halfword/word access off its natural alignment.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      2'b11:   b = d[31:24];
      default: b = 8'h00;
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = d;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign w_req_err = access_err(req_we, req_funct3, req_addr[1:0]);

  // Store lane enables and replicated store data, only while a store is in MEM.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (r_state == S_MEM && r_we) begin
      case (r_funct3)
        3'b000: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        3'b001: begin
          w_be    = 4'b0011 << {r_addr[1], 1'b0};
          w_wdata = {2{r_wdata[15:0]}};
        end
        3'b010: begin
          w_be    = 4'b1111;
          w_wdata = r_wdata;
        end
        default: begin
          w_be    = 4'b0000;
          w_wdata = 32'h0000_0000;
        end
      endcase
    end else begin
      w_be    = 4'b0000;
      w_wdata = 32'h0000_0000;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_MEM);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
  assign mem_be    = w_be;
  assign mem_wdata = w_wdata;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = rsp_valid ? r_rdata : 32'h0000_0000;

  // Access sequencer: capture at acceptance, wait for ack or timeout, one response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_rdata  <= 32'h0000_0000;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'h0000_0000;
            r_err    <= w_req_err;
            r_cnt    <= 8'd0;
            r_state  <= w_req_err ? S_RESP : S_MEM;
          end
        end
        S_MEM: begin
          // An ack on the expiry edge still completes the access cleanly.
          if (mem_ack) begin
            r_rdata <= r_we ? 32'h0000_0000 : load_data(r_funct3, r_addr[1:0], mem_rdata);
            r_state <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0000_0000;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the request inputs.
  task automatic start_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    total++;
    if ({req_ready, mem_req, mem_we, mem_be, rsp_valid, rsp_err} !== 9'b1_0_0_0000_0_0) begin
      $display("FAIL reset_ctrl: got %b want %b",
               {req_ready, mem_req, mem_we, mem_be, rsp_valid, rsp_err}, 9'b1_0_0_0000_0_0);
      bad++;
    end
    total++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rsp_rdata});
      bad++;
    end
  endtask

  task automatic test_lw();
    start_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    total++;
    if ({mem_req, mem_we, mem_be, req_ready, rsp_valid, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0000_0100, 32'h0}) begin
      $display("FAIL lw_mem1: req=%b we=%b be=%b addr=%h wdata=%h want 1 0 0000 00000100 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      bad++;
    end
    tick();
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100}) begin
      $display("FAIL lw_mem3: req=%b addr=%h want 1 00000100", mem_req, mem_addr);
      bad++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    total++;
    if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      $display("FAIL lw_rsp: valid=%b err=%b req=%b rdata=%h want 1 0 0 deadbeef",
               rsp_valid, rsp_err, mem_req, rsp_rdata);
      bad++;
    end
    tick();
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      $display("FAIL lw_pulse: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      bad++;
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b100, 3'b000};
    logic [31:0] ads [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h201, 32'h202};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                             32'h0000_80FF, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      start_req(1'b0, f3s[i], ads[i], 32'h0);
      total++;
      if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b0000, 32'h0000_0200}) begin
        $display("FAIL ld%0d_mem: req=%b be=%b addr=%h want 1 0000 00000200",
                 i, mem_req, mem_be, mem_addr);
        bad++;
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h80FF_0000;
      tick();
      mem_ack   = 1'b0;
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp[i]}) begin
        $display("FAIL ld%0d_rsp: valid=%b err=%b rdata=%h want 1 0 %h",
                 i, rsp_valid, rsp_err, rsp_rdata, exp[i]);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [5] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001};
    logic [31:0] ads [5] = '{32'h12, 32'h21, 32'h30, 32'h33, 32'h40};
    logic [31:0] wds [5] = '{32'h1234_ABCD, 32'h0000_00A5, 32'hCAFE_BABE,
                             32'h1122_3344, 32'hDEAD_8765};
    logic [31:0] eas [5] = '{32'h10, 32'h20, 32'h30, 32'h30, 32'h40};
    logic [3:0]  ebe [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000, 4'b0011};
    logic [31:0] ewd [5] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'hCAFE_BABE,
                             32'h4444_4444, 32'h8765_8765};
    for (int i = 0; i < 5; i++) begin
      start_req(1'b1, f3s[i], ads[i], wds[i]);
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, ebe[i], eas[i], ewd[i]}) begin
        $display("FAIL st%0d_mem: req=%b we=%b be=%b addr=%h wdata=%h want 1 1 %b %h %h",
                 i, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ebe[i], eas[i], ewd[i]);
        bad++;
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack   = 1'b0;
      total++;
      if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        $display("FAIL st%0d_rsp: valid=%b err=%b req=%b rdata=%h want 1 0 0 0",
                 i, rsp_valid, rsp_err, mem_req, rsp_rdata);
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic        wes [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [6] = '{3'b010, 3'b011, 3'b011, 3'b001, 3'b010, 3'b110};
    logic [31:0] ads [6] = '{32'h102, 32'h100, 32'h100, 32'h101, 32'h101, 32'h0};
    mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      start_req(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF);
      total++;
      if ({mem_req, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
        $display("FAIL err%0d_rsp: req=%b valid=%b err=%b rdata=%h want 0 1 1 0",
                 i, mem_req, rsp_valid, rsp_err, rsp_rdata);
        bad++;
      end
      tick();
      total++;
      if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
        $display("FAIL err%0d_idle: req=%b valid=%b ready=%b want 0 0 1",
                 i, mem_req, rsp_valid, req_ready);
        bad++;
      end
    end
  endtask

  task automatic test_timeout();
    int   cnt  = 0;
    logic seen = 1'b0;
    logic err  = 1'b0;
    start_req(1'b0, 3'b010, 32'h40, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        err  = rsp_err;
        break;
      end
      if (mem_req) cnt++;
      tick();
    end
    total++;
    if ({seen, err} !== 2'b11 || cnt != 16) begin
      $display("FAIL timeout: seen=%b err=%b mem_req_cycles=%0d want 1 1 16", seen, err, cnt);
      bad++;
    end
    tick();
    start_req(1'b0, 3'b010, 32'h40, 32'h0);
    for (int i = 1; i < 16; i++) tick();
    total++;
    if (mem_req !== 1'b1) begin
      $display("FAIL timeout_c16: mem_req=%b want 1", mem_req);
      bad++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack   = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1122_3344}) begin
      $display("FAIL timeout_ack: valid=%b err=%b rdata=%h want 1 0 11223344",
               rsp_valid, rsp_err, rsp_rdata);
      bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 3'b010, 32'h100, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_req, req_ready, mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      $display("FAIL rst_async: req=%b ready=%b addr=%h want 0 1 0", mem_req, req_ready, mem_addr);
      bad++;
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin
      $display("FAIL rst_norsp: valid=%b req=%b ready=%b want 0 0 1", rsp_valid, mem_req, req_ready);
      bad++;
    end
    start_req(1'b0, 3'b010, 32'h84, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack   = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      $display("FAIL rst_next: valid=%b err=%b rdata=%h want 1 0 cafef00d",
               rsp_valid, rsp_err, rsp_rdata);
      bad++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin
      $display("FAIL idle_ack: valid=%b req=%b ready=%b want 0 0 1", rsp_valid, mem_req, req_ready);
      bad++;
    end
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h50;
    req_wdata  = 32'hCAFE_BABE;
    tick();
    req_we     = 1'b0;
    req_addr   = 32'h60;
    req_wdata  = 32'h0;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 4'b1111, 32'h50, 32'hCAFE_BABE}) begin
      $display("FAIL b2b_st: req=%b we=%b be=%b addr=%h wdata=%h want 1 1 1111 00000050 cafebabe",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      bad++;
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({rsp_valid, req_ready, mem_req} !== 3'b100) begin
      $display("FAIL b2b_resp: valid=%b ready=%b req=%b want 1 0 0", rsp_valid, req_ready, mem_req);
      bad++;
    end
    tick();
    total++;
    if ({rsp_valid, req_ready, mem_req} !== 3'b010) begin
      $display("FAIL b2b_idle: valid=%b ready=%b req=%b want 0 1 0", rsp_valid, req_ready, mem_req);
      bad++;
    end
    tick();
    req_valid = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h60}) begin
      $display("FAIL b2b_ld: req=%b we=%b addr=%h want 1 0 00000060", mem_req, mem_we, mem_addr);
      bad++;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack   = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
      $display("FAIL b2b_rsp: valid=%b err=%b rdata=%h want 1 0 0badf00d",
               rsp_valid, rsp_err, rsp_rdata);
      bad++;
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_lw();
    test_load_ext();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
